// File: rtl/dijkstra_engine_p.sv
// Shortest-path search over an external node RAM. The path is streamed start-to-goal
// over a valid/ready handshake. Per-node tables hold one entry per cycle of work.
module dijkstra_engine_p #(
    parameter int NODES        = 128,
    parameter int ID_W         = 16,
    parameter int COST_W       = 16,
    parameter int MAX_CHILDREN = 6,
    parameter int PATH_DEPTH   = 100
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ID_W-1:0]                        start_id,
    input  logic [ID_W-1:0]                        goal_id,
    output logic                                   mem_rd,
    output logic [ID_W-1:0]                        mem_addr,
    input  logic [MAX_CHILDREN*(ID_W+COST_W)-1:0]  mem_rdata,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   success,
    output logic [ID_W-1:0]                        path_len,
    output logic                                   path_valid,
    input  logic                                   path_ready,
    output logic [ID_W-1:0]                        path_id,
    output logic                                   path_last
);
    localparam int REC_W  = ID_W + COST_W;
    localparam int IDX_W  = $clog2(NODES + 1);
    localparam int PTR_W  = (PATH_DEPTH > 1) ? $clog2(PATH_DEPTH) : 1;
    localparam int SLOT_W = (MAX_CHILDREN > 1) ? $clog2(MAX_CHILDREN) : 1;
    localparam logic [COST_W-1:0] INF      = '1;
    localparam logic [COST_W-1:0] MAXF     = {{(COST_W-1){1'b1}}, 1'b0};
    localparam logic [ID_W-1:0]   NODES_ID = ID_W'(NODES);
    localparam logic [ID_W-1:0]   SEED_IDX = ID_W'(NODES + 1);
    localparam logic [ID_W-1:0]   DEPTH_ID = ID_W'(PATH_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_INIT, S_SELECT, S_FETCH, S_WAIT, S_RELAX, S_TRACE, S_EMIT
    } state_t;

    state_t                          state_q, state_d;
    logic [ID_W-1:0]                 start_q, start_d, goal_q, goal_d;
    logic [ID_W-1:0]                 idx_q, idx_d, best_q, best_d;
    logic [COST_W-1:0]               best_dist_q, best_dist_d, du_q, du_d;
    logic [MAX_CHILDREN*REC_W-1:0]   rec_q, rec_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic [ID_W-1:0]                 cur_q, cur_d, cnt_q, cnt_d;
    logic [PTR_W-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2**IDX_W-1:0]             visited_q, visited_d;
    logic                            mem_rd_q, mem_rd_d, busy_q, busy_d, done_q, done_d;
    logic                            success_q, success_d, path_valid_q, path_valid_d;
    logic                            path_last_q, path_last_d;
    logic [ID_W-1:0]                 mem_addr_q, mem_addr_d, path_len_q, path_len_d;
    logic [ID_W-1:0]                 path_id_q, path_id_d;

    logic [COST_W-1:0] dist_mem   [2**IDX_W];
    logic [ID_W-1:0]   parent_mem [2**IDX_W];
    logic [ID_W-1:0]   path_mem   [2**PTR_W];

    logic              dist_we, par_we, path_we;
    logic [IDX_W-1:0]  dist_wa, par_wa;
    logic [PTR_W-1:0]  path_wa;
    logic [COST_W-1:0] dist_wd;
    logic [ID_W-1:0]   par_wd, path_wd;

    always_ff @(posedge clk) begin
        if (dist_we) dist_mem[dist_wa] <= dist_wd;
        if (par_we)  parent_mem[par_wa] <= par_wd;
        if (path_we) path_mem[path_wa] <= path_wd;
    end

    logic [ID_W-1:0]   slot_child [2**SLOT_W];
    logic [COST_W-1:0] slot_cost  [2**SLOT_W];
    for (genvar gi = 0; gi < 2**SLOT_W; gi++) begin : g_slot
        if (gi < MAX_CHILDREN) begin : g_used
            assign slot_cost[gi]  = rec_q[gi*REC_W +: COST_W];
            assign slot_child[gi] = rec_q[gi*REC_W + COST_W +: ID_W];
        end else begin : g_pad
            assign slot_cost[gi]  = '0;
            assign slot_child[gi] = '0;
        end
    end

    // Scan: strict less-than keeps the lowest ID on equal distances.
    logic [IDX_W-1:0]  scan_a;
    logic [COST_W-1:0] scan_dist, sel_dist;
    logic              scan_better;
    logic [ID_W-1:0]   sel_id;
    assign scan_a      = idx_q[IDX_W-1:0];
    assign scan_dist   = dist_mem[scan_a];
    assign scan_better = !visited_q[scan_a] && (scan_dist != INF)
                         && ((best_q == '0) || (scan_dist < best_dist_q));
    assign sel_id      = scan_better ? idx_q : best_q;
    assign sel_dist    = scan_better ? scan_dist : best_dist_q;

    logic [ID_W-1:0]   child;
    logic [IDX_W-1:0]  child_a;
    logic [COST_W:0]   sum;
    logic [COST_W-1:0] relax_cost;
    logic              relax_upd;
    assign child      = slot_child[slot_q];
    assign child_a    = child[IDX_W-1:0];
    assign sum        = {1'b0, du_q} + {1'b0, slot_cost[slot_q]};
    assign relax_cost = (sum > {1'b0, MAXF}) ? MAXF : sum[COST_W-1:0];
    assign relax_upd  = (child != '0) && (child <= NODES_ID) && !visited_q[child_a]
                        && (relax_cost < dist_mem[child_a]);

    always_comb begin
        state_d = state_q;   start_d = start_q;   goal_d = goal_q;
        idx_d = idx_q;       best_d = best_q;     best_dist_d = best_dist_q;
        du_d = du_q;         rec_d = rec_q;       slot_d = slot_q;
        cur_d = cur_q;       cnt_d = cnt_q;       wptr_d = wptr_q;   rptr_d = rptr_q;
        visited_d = visited_q;
        mem_rd_d = 1'b0;     mem_addr_d = mem_addr_q;
        busy_d = busy_q;     done_d = 1'b0;       success_d = success_q;
        path_len_d = path_len_q;   path_valid_d = path_valid_q;
        path_id_d = path_id_q;     path_last_d = path_last_q;
        dist_we = 1'b0;  dist_wa = scan_a;  dist_wd = INF;
        par_we  = 1'b0;  par_wa  = scan_a;  par_wd  = '0;
        path_we = 1'b0;  path_wa = wptr_q;  path_wd = cur_q;
        case (state_q)
            S_IDLE: if (start) begin
                start_d = start_id;  goal_d = goal_id;  busy_d = 1'b1;
                success_d = 1'b0;    path_len_d = '0;   state_d = S_CHECK;
            end
            S_CHECK: begin
                if (start_q == '0 || start_q > NODES_ID || goal_q == '0 || goal_q > NODES_ID) begin
                    done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
                end else begin
                    idx_d = ID_W'(1);  state_d = S_INIT;
                end
            end
            S_INIT: begin
                dist_we = 1'b1;
                if (idx_q == SEED_IDX) begin
                    dist_wa = start_q[IDX_W-1:0];  dist_wd = '0;
                    idx_d = ID_W'(1);  best_d = '0;  state_d = S_SELECT;
                end else begin
                    par_we = 1'b1;  visited_d[scan_a] = 1'b0;  idx_d = idx_q + 1'b1;
                end
            end
            S_SELECT: begin
                best_d = sel_id;  best_dist_d = sel_dist;  idx_d = idx_q + 1'b1;
                if (idx_q == NODES_ID) begin
                    idx_d = ID_W'(1);  best_d = '0;
                    if (sel_id == '0) begin
                        done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
                    end else if (sel_id == goal_q) begin
                        cur_d = goal_q;  cnt_d = '0;  wptr_d = PTR_W'(PATH_DEPTH - 1);
                        state_d = S_TRACE;
                    end else begin
                        visited_d[sel_id[IDX_W-1:0]] = 1'b1;
                        mem_rd_d = 1'b1;  mem_addr_d = sel_id;  du_d = sel_dist;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                rec_d = mem_rdata;  slot_d = '0;  state_d = S_RELAX;
            end
            S_RELAX: begin
                if (relax_upd) begin
                    dist_we = 1'b1;  dist_wa = child_a;  dist_wd = relax_cost;
                    par_we  = 1'b1;  par_wa  = child_a;  par_wd  = mem_addr_q;
                end
                slot_d = slot_q + 1'b1;
                if (slot_q == SLOT_W'(MAX_CHILDREN - 1)) state_d = S_SELECT;
            end
            S_TRACE: begin
                if (cnt_q == DEPTH_ID) begin
                    done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
                end else begin
                    path_we = 1'b1;
                    if (cur_q == start_q) begin
                        done_d = 1'b1;  success_d = 1'b1;  path_len_d = cnt_q + 1'b1;
                        path_valid_d = 1'b1;  path_id_d = cur_q;
                        path_last_d = (cnt_q == '0);  rptr_d = wptr_q + 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        cur_d = parent_mem[cur_q[IDX_W-1:0]];
                        wptr_d = wptr_q - 1'b1;  cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_EMIT: if (path_ready) begin
                if (path_last_q) begin
                    path_valid_d = 1'b0;  path_last_d = 1'b0;  busy_d = 1'b0;  state_d = S_IDLE;
                end else begin
                    path_id_d = path_mem[rptr_q];
                    path_last_d = (rptr_q == PTR_W'(PATH_DEPTH - 1));
                    rptr_d = rptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;  start_q <= '0;  goal_q <= '0;  idx_q <= '0;  best_q <= '0;
            best_dist_q <= '0;  du_q <= '0;  rec_q <= '0;  slot_q <= '0;  cur_q <= '0;
            cnt_q <= '0;  wptr_q <= '0;  rptr_q <= '0;  visited_q <= '0;
            mem_rd_q <= 1'b0;  mem_addr_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;
            success_q <= 1'b0;  path_len_q <= '0;  path_valid_q <= 1'b0;
            path_id_q <= '0;  path_last_q <= 1'b0;
        end else begin
            state_q <= state_d;  start_q <= start_d;  goal_q <= goal_d;  idx_q <= idx_d;
            best_q <= best_d;  best_dist_q <= best_dist_d;  du_q <= du_d;  rec_q <= rec_d;
            slot_q <= slot_d;  cur_q <= cur_d;  cnt_q <= cnt_d;  wptr_q <= wptr_d;
            rptr_q <= rptr_d;  visited_q <= visited_d;
            mem_rd_q <= mem_rd_d;  mem_addr_q <= mem_addr_d;  busy_q <= busy_d;
            done_q <= done_d;  success_q <= success_d;  path_len_q <= path_len_d;
            path_valid_q <= path_valid_d;  path_id_q <= path_id_d;  path_last_q <= path_last_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign path_len   = path_len_q;
    assign path_valid = path_valid_q;
    assign path_id    = path_id_q;
    assign path_last  = path_last_q;
endmodule

// File: tb/tb_dijkstra_engine_p.sv
// Bench for dijkstra_engine_p: directed graphs plus random graphs, each search
// compared against a software shortest-path model and the streamed path.
module tb_dijkstra_engine_p;
    localparam int NODES  = 16;
    localparam int ID_W   = 16;
    localparam int COST_W = 8;
    localparam int MC     = 6;
    localparam int DEPTH  = 8;
    localparam int REC_W  = ID_W + COST_W;
    localparam int RD_W   = MC * REC_W;
    localparam int INF    = (1 << COST_W) - 1;

    logic            clk, reset, start, mem_rd, busy, done, success;
    logic            path_valid, path_ready, path_last;
    logic [ID_W-1:0] start_id, goal_id, mem_addr, path_len, path_id;
    logic [RD_W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int g_child [NODES+1][MC];
    int g_cost  [NODES+1][MC];
    int exp_ok, exp_len;
    int exp_path[$];
    int pat[4] = '{1, 0, 0, 1};

    dijkstra_engine_p #(.NODES(NODES), .ID_W(ID_W), .COST_W(COST_W),
                        .MAX_CHILDREN(MC), .PATH_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_id(start_id), .goal_id(goal_id),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .success(success), .path_len(path_len),
        .path_valid(path_valid), .path_ready(path_ready), .path_id(path_id),
        .path_last(path_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RD_W-1:0] pack_node(int n);
        logic [RD_W-1:0] r;
        r = '0;
        if (n >= 0 && n <= NODES)
            for (int k = 0; k < MC; k++) begin
                r[k*REC_W +: COST_W]        = COST_W'(g_cost[n][k]);
                r[k*REC_W + COST_W +: ID_W] = ID_W'(g_child[n][k]);
            end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= pack_node(int'(mem_addr));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_graph();
        for (int n = 0; n <= NODES; n++)
            for (int k = 0; k < MC; k++) begin
                g_child[n][k] = 0;
                g_cost[n][k]  = 0;
            end
    endtask

    task automatic add_edge(input int u, input int slot, input int c, input int w);
        g_child[u][slot] = c;
        g_cost[u][slot]  = w;
    endtask

    task automatic random_graph();
        for (int n = 0; n <= NODES; n++)
            for (int k = 0; k < MC; k++) begin
                g_cost[n][k]  = $urandom_range(0, INF - 1);
                g_child[n][k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NODES + 2) : 0;
            end
    endtask

    // Textbook Dijkstra on the graph tables, then walk parents back from the goal.
    task automatic model(input int s, input int g);
        int d[NODES+1];
        int p[NODES+1];
        bit vis[NODES+1];
        int chain[$];
        int u, c, nd, n;
        exp_ok = 0;
        exp_len = 0;
        exp_path.delete();
        if (s < 1 || s > NODES || g < 1 || g > NODES) return;
        for (int i = 0; i <= NODES; i++) begin
            d[i] = INF; p[i] = 0; vis[i] = 0;
        end
        d[s] = 0;
        forever begin
            u = 0;
            for (int i = 1; i <= NODES; i++)
                if (!vis[i] && d[i] != INF && (u == 0 || d[i] < d[u])) u = i;
            if (u == 0) return;
            if (u == g) break;
            vis[u] = 1;
            for (int k = 0; k < MC; k++) begin
                c = g_child[u][k];
                if (c >= 1 && c <= NODES && !vis[c]) begin
                    nd = d[u] + g_cost[u][k];
                    if (nd > INF - 1) nd = INF - 1;
                    if (nd < d[c]) begin d[c] = nd; p[c] = u; end
                end
            end
        end
        n = g;
        chain.push_front(n);
        while (n != s) begin
            n = p[n];
            chain.push_front(n);
            if (chain.size() > DEPTH) return;
        end
        exp_ok = 1;
        exp_len = chain.size();
        exp_path = chain;
    endtask

    // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic run_search(input int s, input int g, input int rmode, input bit poke);
        int cyc, i, k;
        bit hs;
        model(s, g);
        @(posedge clk); #1;
        start = 1'b1; start_id = ID_W'(s); goal_id = ID_W'(g);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1);
        cyc = 1;
        k = 0;
        while (!done && cyc < 5000) begin
            if (poke && cyc == 3) begin
                start = 1'b1; start_id = ID_W'(g); goal_id = ID_W'(s);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (done) begin
            if (s < 1 || s > NODES || g < 1 || g > NODES) check("done_latency", cyc, 2);
            check("success", success, exp_ok);
            check("path_len", path_len, exp_len);
            check("valid_with_done", path_valid, exp_ok);
            if (exp_ok == 0) begin
                check("busy_fail", busy, 0);
                @(posedge clk); #1;
                check("done_pulse", done, 0);
            end else begin
                i = 0;
                while (i < exp_len && k < 400) begin
                    path_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[k % 4][0] : 1'($urandom_range(0, 1));
                    check("beat_valid", path_valid, 1);
                    check("beat_id", path_id, exp_path[i]);
                    check("beat_last", path_last, (i == exp_len - 1));
                    hs = path_valid && path_ready;
                    @(posedge clk); #1;
                    k++;
                    if (hs) i++;
                end
                path_ready = 1'b0;
                check("beat_count", i, exp_len);
                check("valid_drop", path_valid, 0);
                check("busy_end", busy, 0);
            end
        end
        $display("search start=%0d goal=%0d ok=%0d len=%0d cycles=%0d", s, g, exp_ok, exp_len, cyc);
    endtask

    initial begin
        int k;
        reset = 1'b0; start = 1'b0; start_id = '0; goal_id = '0; path_ready = 1'b0;
        clear_graph();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);          check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);      check("rst_mem_addr", mem_addr, 0);
        check("rst_success", success, 0);    check("rst_path_len", path_len, 0);
        check("rst_path_valid", path_valid, 0);
        check("rst_path_id", path_id, 0);    check("rst_path_last", path_last, 0);
        reset = 1'b1;

        add_edge(1, 0, 2, 4); add_edge(2, 0, 3, 2);
        run_search(1, 3, 0, 0);

        clear_graph();
        add_edge(1, 0, 3, 5); add_edge(1, 1, 2, 5); add_edge(2, 3, 4, 1); add_edge(3, 5, 4, 1);
        run_search(1, 4, 0, 1);
        run_search(5, 5, 0, 0);
        run_search(1, 7, 0, 0);
        run_search(0, 3, 0, 0);
        run_search(1, NODES + 1, 0, 0);

        clear_graph();
        add_edge(1, 0, 2, 200); add_edge(1, 1, 3, 254); add_edge(2, 0, 3, 200);
        run_search(1, 3, 0, 0);

        clear_graph();
        for (int i = 1; i < 10; i++) add_edge(i, i % MC, i + 1, $urandom_range(1, 30));
        run_search(1, 6, 1, 0);
        run_search(1, 8, 1, 0);
        run_search(1, 10, 0, 0);

        // Abort a search while it is relaxing children, then rerun it.
        @(posedge clk); #1;
        start = 1'b1; start_id = ID_W'(1); goal_id = ID_W'(6);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!mem_rd && k < 2000) begin @(posedge clk); #1; k++; end
        check("fetch_seen", mem_rd, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);        check("abort_done", done, 0);
        check("abort_mem_rd", mem_rd, 0);    check("abort_mem_addr", mem_addr, 0);
        check("abort_success", success, 0);  check("abort_path_len", path_len, 0);
        check("abort_valid", path_valid, 0); check("abort_path_id", path_id, 0);
        check("abort_last", path_last, 0);
        @(posedge clk); #1;
        check("abort_no_done", done, 0);
        reset = 1'b1;
        run_search(1, 6, 0, 0);

        for (int t = 0; t < 6; t++) begin
            random_graph();
            for (int j = 0; j < 4; j++)
                run_search($urandom_range(1, NODES), $urandom_range(1, NODES), 2, (j == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dijkstra_engine_p.md
# dijkstra_engine_p

Parametrised shortest-path engine for the SmartCart store map: next generation of the fixed six-child Dijkstra block. Node count, ID/cost widths, child fan-out and path depth are parameters. Node adjacency is read from an external node RAM rather than passed as structs. The path is delivered as a valid/ready stream, ordered start-to-goal, to the path-upload logic on the HPS bridge.

## Interface
- NODES, 128: valid node IDs are 1..NODES; ID 0 means "no child / null".
- ID_W, 16: node ID width.
- COST_W, 16: edge/path cost width; all-ones is reserved as infinity.
- MAX_CHILDREN, 6: child slots per node record.
- PATH_DEPTH, 100: maximum path length in nodes.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  one-cycle request pulse; ignored while busy.
- start_id, goal_id  in  ID_W  endpoints, sampled when start is accepted.
- mem_rd  out  1  node RAM read strobe.
- mem_addr  out  ID_W  node ID to read.
- mem_rdata  in  MAX_CHILDREN*2*... packed {child_id[ID_W], dist[COST_W]} × MAX_CHILDREN; slot 0 in LSBs; valid exactly 1 cycle after mem_rd.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of search.
- success  out  1  result; held until next accepted start.
- path_len  out  ID_W  node count of path, valid with done, held.
- path_valid, path_ready  out/in  1  stream handshake.
- path_id  out  ID_W  path node; path_last  out  1  marks goal.

## Operation
- Internal state: dist[1..NODES] (COST_W), parent[1..NODES] (ID_W), visited[1..NODES], path buffer of PATH_DEPTH.
- States: IDLE → CHECK → INIT → SELECT → FETCH → WAIT → RELAX → (SELECT | TRACE) → EMIT → IDLE.
- IDLE: on start, latch IDs, set busy, go to CHECK.
- CHECK: start_id or goal_id equal to 0 or greater than NODES → done, success=0, path_len=0, IDLE.
- INIT: one node per cycle (NODES cycles). Sets dist=∞, visited=0, parent=0. Then dist[start]=0.
- SELECT: linear scan over NODES cycles for the unvisited node with minimum finite dist; ties go to the lowest ID.
  - No candidate → done, success=0, IDLE.
  - Selected node == goal → TRACE.
  - Otherwise mark the node visited and go to FETCH.
- FETCH: assert mem_rd one cycle with mem_addr = selected ID; WAIT captures mem_rdata.
- RELAX: one child slot per cycle (MAX_CHILDREN cycles).
  - Skip a slot when child_id is 0, greater than NODES, or already visited.
  - new = dist[u] + d, saturating at 2^COST_W − 2.
  - Update dist and parent only if new < dist[child]; equal cost keeps the existing parent.
- TRACE: follow parent from goal, writing the buffer from the top down.
  - Exceeding PATH_DEPTH → done, success=0, path_len=0, IDLE.
  - Reaching start → success=1, path_len set, done pulse, EMIT.
- EMIT: stream buffer start-first. path_id changes only on path_valid && path_ready. path_last marks the final beat. After the last handshake → IDLE, busy=0.
- start == goal: path_len=1, single beat with path_last=1.

## Timing
- Reset values: mem_rd=0, mem_addr=0, busy=0, done=0, success=0, path_len=0, path_valid=0, path_id=0, path_last=0; FSM=IDLE.
- Reset asserted mid-search or mid-stream aborts immediately with no done pulse.
- busy rises the cycle after start is sampled.
- Invalid-ID result: done 2 cycles after start.
- Search latency: 1 + NODES + 1 + V·(NODES + 2 + MAX_CHILDREN) + NODES (final SELECT) + (path_len + 1) cycles for TRACE, where V = nodes expanded.
- done rises the cycle TRACE ends (or on failure). path_valid rises the same cycle as done on success.
- start asserted while busy: no effect, including no re-latch of IDs.
- Stream: path_valid held with a stable path_id until ready; one beat per cycle at full throughput.

## Test plan
- Line graph 1→2→3 (costs 4, 2), start 1, goal 3 → success=1, path_len=3, stream 1,2,3, last on 3.
- Diamond 1→2 (5), 1→3 (5), 2→4 (1), 3→4 (1) → path 1,2,4 (tie goes to lower ID and strict-less relax).
- start_id = goal_id = 5 → success=1, path_len=1, single beat 5 with last.
- Goal unreachable (node 7 has no in-edges) → done with success=0, path_len=0, no path_valid.
- start_id=0 or goal_id=NODES+1 → done exactly 2 cycles after start, success=0.
- Line path with path_ready toggling 1,0,0,1 → no beat lost or duplicated. Reset asserted mid-RELAX on a second run → all outputs 0 at once, and the next start completes correctly.
